// File: rtl/alu_seq_if.sv
// Command, response and ALU-side signals of the sequencer.
// The slave modport is the sequencer; the master is the environment (control path plus ALU).
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic [7:0] acc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_out, alu_carry, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data,
           rsp_carry, rsp_err, acc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_out, alu_carry, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data,
           rsp_carry, rsp_err, acc
  );
endinterface

// File: rtl/alu_seq.sv
// Accumulator command sequencer in front of an external 8-bit AND/OR/ADD/SUB ALU.
// Non-MUL commands answer 2 cycles after accept and MUL after 9; one command is in flight at a time.
module alu_seq (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [1:0] ALU_ADD = 2'b10;

  state_t     state, state_nx;
  logic [2:0] op_q;
  logic [7:0] data_q;
  logic [7:0] acc_q;
  logic [1:0] opc_q;
  logic [7:0] a_q, b_q;
  logic [7:0] rdata_q;
  logic       rcarry_q, rerr_q;
  logic [7:0] m_q, q_q, p_q;
  logic [2:0] i_q;
  logic       ovf_q;

  logic        accept;
  logic [15:0] m_sh;
  logic        take;
  logic [7:0]  p_nx;
  logic        ovf_nx;
  logic [2:0]  i_nx;
  logic [7:0]  m_sh_nx;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign m_sh    = {8'h00, m_q} << i_q;
  assign take    = q_q[i_q];
  assign p_nx    = take ? bus.alu_out : p_q;
  // Product exceeds 8 bits if a taken add carries out or a taken partial product lost bits.
  assign ovf_nx  = ovf_q | (take & (bus.alu_carry | (m_sh[15:8] != 8'h00)));
  assign i_nx    = i_q + 3'd1;
  assign m_sh_nx = m_q << i_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nx = (bus.cmd_op == OP_MUL) ? MUL : EXEC;
      end
      EXEC: state_nx = RESP;
      MUL:  if (i_q == 3'd7) state_nx = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= 3'd0;
      data_q   <= 8'h00;
      acc_q    <= 8'h00;
      opc_q    <= 2'b00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      rdata_q  <= 8'h00;
      rcarry_q <= 1'b0;
      rerr_q   <= 1'b0;
      m_q      <= 8'h00;
      q_q      <= 8'h00;
      p_q      <= 8'h00;
      i_q      <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.cmd_op;
          data_q <= bus.cmd_data;
          if (bus.cmd_op == OP_MUL) begin
            opc_q <= ALU_ADD;
            a_q   <= 8'h00;
            b_q   <= acc_q;
            m_q   <= acc_q;
            q_q   <= bus.cmd_data;
            p_q   <= 8'h00;
            i_q   <= 3'd0;
            ovf_q <= 1'b0;
          end else if (!bus.cmd_op[2]) begin
            opc_q <= bus.cmd_op[1:0];
            a_q   <= acc_q;
            b_q   <= bus.cmd_data;
          end
        end
        EXEC: begin
          rcarry_q <= 1'b0;
          if (!op_q[2]) begin
            acc_q   <= bus.alu_out;
            rdata_q <= bus.alu_out;
            if (op_q[1]) rcarry_q <= bus.alu_carry;
          end else if (op_q == OP_LOAD) begin
            acc_q   <= data_q;
            rdata_q <= data_q;
          end else begin
            rdata_q <= acc_q;
            rerr_q  <= 1'b1;
          end
        end
        MUL: begin
          p_q   <= p_nx;
          ovf_q <= ovf_nx;
          i_q   <= i_nx;
          a_q   <= p_nx;
          b_q   <= m_sh_nx;
          if (i_q == 3'd7) begin
            acc_q    <= p_nx;
            rdata_q  <= p_nx;
            rcarry_q <= ovf_nx;
          end
        end
        RESP: if (bus.rsp_ready) rerr_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.acc        = acc_q;
  assign bus.alu_opcode = opc_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_data   = rdata_q;
  assign bus.rsp_carry  = rcarry_q;
  assign bus.rsp_err    = rerr_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, table of commands with expected responses, scoreboard queue.
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if bus();
  alu_seq dut (.clk(clk), .reset(reset), .bus(bus));

  // Combinational ALU the sequencer drives
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (bus.alu_opcode)
      2'b00: alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      2'b01: alu_sum = {1'b0, bus.alu_a | bus.alu_b};
      2'b10: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      default: alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
    endcase
  end
  assign bus.alu_out   = alu_sum[7:0];
  assign bus.alu_carry = alu_sum[8];

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_err;
    int         lat;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] model_acc = 8'h00;
  vec_t v1[16];
  vec_t v2[4];

  function automatic vec_t mk(logic [2:0] op, logic [7:0] d, logic [7:0] ed, logic ec, logic ee);
    vec_t v;
    v.op = op; v.data = d; v.exp_data = ed; v.exp_carry = ec; v.exp_err = ee;
    v.lat = (op == 3'd5) ? 9 : 2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp_data"},  bus.rsp_data,  e.d);
      chk({tag, "_rsp_carry"}, bus.rsp_carry, e.c);
      chk({tag, "_rsp_err"},   bus.rsp_err,   e.e);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    sb.push_back({v.exp_data, v.exp_carry, v.exp_err});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (!v.op[2]) begin
      chk({tag, "_alu_opcode"}, bus.alu_opcode, v.op[1:0]);
      chk({tag, "_alu_a"},      bus.alu_a,      model_acc);
      chk({tag, "_alu_b"},      bus.alu_b,      v.data);
    end
    n = 1;
    while (!bus.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, n, v.lat);
    pop_check(tag);
    @(posedge clk); #1;
    chk({tag, "_acc"},       bus.acc,       v.exp_data);
    chk({tag, "_rsp_clear"}, bus.rsp_valid, 0);
    model_acc = v.exp_data;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"},  bus.cmd_ready,  1);
    chk({tag, "_acc"},        bus.acc,        8'h00);
    chk({tag, "_alu_opcode"}, bus.alu_opcode, 2'b00);
    chk({tag, "_alu_a"},      bus.alu_a,      8'h00);
    chk({tag, "_alu_b"},      bus.alu_b,      8'h00);
    chk({tag, "_rsp_valid"},  bus.rsp_valid,  0);
    chk({tag, "_rsp_data"},   bus.rsp_data,   8'h00);
    chk({tag, "_rsp_carry"},  bus.rsp_carry,  0);
    chk({tag, "_rsp_err"},    bus.rsp_err,    0);
  endtask

  initial begin
    int n;
    v1[0]  = mk(3'd4, 8'h5A, 8'h5A, 1'b0, 1'b0);
    v1[1]  = mk(3'd4, 8'hF0, 8'hF0, 1'b0, 1'b0);
    v1[2]  = mk(3'd2, 8'h20, 8'h10, 1'b1, 1'b0);
    v1[3]  = mk(3'd3, 8'h11, 8'hFF, 1'b0, 1'b0);
    v1[4]  = mk(3'd3, 8'h0F, 8'hF0, 1'b1, 1'b0);
    v1[5]  = mk(3'd4, 8'hCC, 8'hCC, 1'b0, 1'b0);
    v1[6]  = mk(3'd0, 8'h0F, 8'h0C, 1'b0, 1'b0);
    v1[7]  = mk(3'd1, 8'hA0, 8'hAC, 1'b0, 1'b0);
    v1[8]  = mk(3'd4, 8'd13, 8'h0D, 1'b0, 1'b0);
    v1[9]  = mk(3'd5, 8'd11, 8'h8F, 1'b0, 1'b0);
    v1[10] = mk(3'd4, 8'h20, 8'h20, 1'b0, 1'b0);
    v1[11] = mk(3'd5, 8'h10, 8'h00, 1'b1, 1'b0);
    v1[12] = mk(3'd4, 8'hFF, 8'hFF, 1'b0, 1'b0);
    v1[13] = mk(3'd5, 8'h00, 8'h00, 1'b0, 1'b0);
    v1[14] = mk(3'd4, 8'h0F, 8'h0F, 1'b0, 1'b0);
    v1[15] = mk(3'd5, 8'h11, 8'hFF, 1'b0, 1'b0);
    v2[0]  = mk(3'd6, 8'h99, 8'h3C, 1'b0, 1'b1);
    v2[1]  = mk(3'd7, 8'h55, 8'h3C, 1'b0, 1'b1);
    v2[2]  = mk(3'd2, 8'h01, 8'h3D, 1'b0, 1'b0);
    v2[3]  = mk(3'd3, 8'h3D, 8'h00, 1'b1, 1'b0);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int k = 0; k < 16; k++) run_vec(v1[k], $sformatf("v1_%0d", k));

    // Response held while the consumer stalls; a waiting command must not be taken
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_data  = 8'h3C;
    sb.push_back({8'h3C, 1'b0, 1'b0});
    @(posedge clk); #1;
    bus.cmd_op   = 3'd2;
    bus.cmd_data = 8'h01;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    pop_check("stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold_valid", bus.rsp_valid, 1);
      chk("stall_cmd_ready",  bus.cmd_ready, 0);
      chk("stall_hold_data",  bus.rsp_data,  8'h3C);
      chk("stall_hold_carry", bus.rsp_carry, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("stall_done_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    chk("stall_no_extra_acc", bus.acc,       8'h3C);
    chk("stall_cmd_ready_back", bus.cmd_ready, 1);
    model_acc = 8'h3C;

    for (int k = 0; k < 4; k++) run_vec(v2[k], $sformatf("v2_%0d", k));

    // Reset in the fourth MUL cycle drops the command
    run_vec(mk(3'd4, 8'h07, 8'h07, 1'b0, 1'b0), "pre_rst_load");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_data  = 8'h03;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_mul_reset");
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    chk("mid_mul_no_rsp", n, 0);
    model_acc = 8'h00;
    run_vec(mk(3'd4, 8'h01, 8'h01, 1'b0, 1'b0), "post_rst_load");

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
